alu_issue_ctrl: RTL and testbench

- Sequential front-end for the 4-bit combinational ALU (ops ADD 000, SUB 001, AND 010, OR 011, NOT 100).
- Accepts commands over a valid/ready handshake and registers the operands onto the ALU's A/B/Opcode inputs.
- Captures Result/Zero/Carry one cycle later into an accumulator and response registers, then presents the response over a valid/ready handshake.
- Sits directly upstream of the ALU (drives it) and directly downstream of it (consumes its outputs).

---
 rtl/alu_issue_ctrl.sv | 105 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/response controller for a 4-bit combinational ALU.
// Registers each accepted command onto the ALU inputs, then captures the ALU outputs one cycle later.
module alu_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_Opcode,
    input  logic [WIDTH-1:0] alu_Result,
    input  logic             alu_Zero,
    input  logic             alu_Carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic             accept;
    logic             legal;

    // Legal opcodes: ADD, SUB, AND, OR, NOT (000..100).
    assign legal  = (cmd_op <= 3'd4);
    assign accept = cmd_valid && cmd_ready;

    assign alu_A      = a_r;
    assign alu_B      = b_r;
    assign alu_Opcode = op_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = legal ? EXEC : RESP;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            acc        <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                a_r  <= cmd_use_acc ? acc : cmd_a;
                b_r  <= cmd_b;
                op_r <= cmd_op;
                // Illegal ops skip the ALU and answer straight away with an error.
                if (!legal) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                    rsp_carry  <= 1'b0;
                    rsp_err    <= 1'b1;
                end
            end
            if (state == EXEC) begin
                rsp_result <= alu_Result;
                rsp_zero   <= alu_Zero;
                rsp_carry  <= alu_Carry;
                rsp_err    <= 1'b0;
                acc        <= alu_Result;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a default-width instance plus a CNT_W=2 instance
// driven by the same commands, each fed by its own combinational ALU.
module tb_alu_issue_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic         cmd_use_acc = 1'b0;
    logic         rsp_ready = 1'b1;

    logic         cmd_ready, rsp_valid, rsp_zero, rsp_carry, rsp_err;
    logic [W-1:0] alu_A, alu_B, alu_Result, rsp_result, acc;
    logic [2:0]   alu_Opcode;
    logic         alu_Zero, alu_Carry;
    logic [7:0]   op_count;

    logic         w_cmd_ready, w_rsp_valid, w_rsp_zero, w_rsp_carry, w_rsp_err;
    logic [W-1:0] w_alu_A, w_alu_B, w_alu_Result, w_rsp_result, w_acc;
    logic [2:0]   w_alu_Opcode;
    logic         w_alu_Zero, w_alu_Carry;
    logic [1:0]   w_op_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference ALU: {carry, zero, result}; SUB reports borrow on Carry.
    function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        s = '0;
        c = 1'b0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            3'b001: begin r = a - b; c = (a < b); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = ~a;
            default: r = '0;
        endcase
        return {c, (r == '0), r};
    endfunction

    assign {alu_Carry, alu_Zero, alu_Result}       = alu_f(alu_A, alu_B, alu_Opcode);
    assign {w_alu_Carry, w_alu_Zero, w_alu_Result} = alu_f(w_alu_A, w_alu_B, w_alu_Opcode);

    alu_issue_ctrl #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Opcode(alu_Opcode),
        .alu_Result(alu_Result), .alu_Zero(alu_Zero), .alu_Carry(alu_Carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .acc(acc), .op_count(op_count)
    );

    alu_issue_ctrl #(.WIDTH(W), .CNT_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_A(w_alu_A), .alu_B(w_alu_B), .alu_Opcode(w_alu_Opcode),
        .alu_Result(w_alu_Result), .alu_Zero(w_alu_Zero), .alu_Carry(w_alu_Carry),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(w_rsp_result),
        .rsp_zero(w_rsp_zero), .rsp_carry(w_rsp_carry), .rsp_err(w_rsp_err),
        .acc(w_acc), .op_count(w_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command: accept, optional EXEC, RESP, then back to IDLE (rsp_ready held high).
    task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ua, input logic [W-1:0] exp_a,
                         input logic [W-1:0] exp_r, input logic exp_z, input logic exp_c,
                         input logic [W-1:0] exp_acc, input logic [7:0] exp_cnt,
                         input logic [1:0] exp_wcnt);
        logic bad;
        bad = (op > 3'd4);
        chk({tag, " cmd_ready idle"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        step();
        cmd_valid = 1'b0;
        if (!bad) begin
            chk({tag, " exec rsp_valid"}, rsp_valid, 0);
            chk({tag, " exec cmd_ready"}, cmd_ready, 0);
            chk({tag, " alu_A"}, alu_A, exp_a);
            chk({tag, " alu_B"}, alu_B, b);
            chk({tag, " alu_Opcode"}, alu_Opcode, op);
            step();
        end
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_result"}, rsp_result, exp_r);
        chk({tag, " rsp_zero"}, rsp_zero, exp_z);
        chk({tag, " rsp_carry"}, rsp_carry, exp_c);
        chk({tag, " rsp_err"}, rsp_err, bad);
        chk({tag, " acc"}, acc, exp_acc);
        chk({tag, " op_count"}, op_count, exp_cnt);
        chk({tag, " wrap op_count"}, w_op_count, exp_wcnt);
        step();
        chk({tag, " rsp_valid drop"}, rsp_valid, 0);
    endtask

    initial begin
        #2;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst acc", acc, 0);
        chk("rst op_count", op_count, 0);
        chk("rst alu_A", alu_A, 0);
        chk("rst rsp_err", rsp_err, 0);
        step();
        rst_n = 1'b1;
        step();

        //     tag      op      a      b      ua  alu_A  res    z  c  acc    cnt  wcnt
        do_op("add",   3'b000, 4'd3, 4'd5,  0, 4'd3,  4'd8,  0, 0, 4'd8,  1,   1);
        do_op("sub",   3'b001, 4'd0, 4'd2,  1, 4'd8,  4'd6,  0, 0, 4'd6,  2,   2);
        do_op("addz",  3'b000, 4'd0, 4'd10, 1, 4'd6,  4'd0,  1, 1, 4'd0,  3,   3);
        do_op("not",   3'b100, 4'd5, 4'd0,  0, 4'd5,  4'hA,  0, 0, 4'hA,  4,   0);
        do_op("ill",   3'b110, 4'd7, 4'd0,  0, 4'd7,  4'd0,  0, 0, 4'hA,  4,   0);

        // Backpressure: response held while a second command waits.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'd1; cmd_b = 4'd2; cmd_use_acc = 1'b0;
        step();
        cmd_op = 3'b010; cmd_a = 4'hF; cmd_b = 4'd6;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", rsp_valid, 1);
            chk("bp rsp_result", rsp_result, 4'd3);
            chk("bp cmd_ready", cmd_ready, 0);
            chk("bp acc", acc, 4'd3);
            step();
        end
        chk("bp op_count", op_count, 5);
        chk("bp wrap op_count", w_op_count, 1);
        rsp_ready = 1'b1;
        step();
        chk("bp idle cmd_ready", cmd_ready, 1);
        chk("bp idle rsp_valid", rsp_valid, 0);
        step();
        cmd_valid = 1'b0;
        chk("bp pend alu_A", alu_A, 4'hF);
        chk("bp pend alu_Opcode", alu_Opcode, 3'b010);
        step();
        chk("bp pend rsp_result", rsp_result, 4'd6);
        chk("bp pend op_count", op_count, 6);
        chk("bp pend wrap op_count", w_op_count, 2);
        step();

        // Async reset in EXEC discards the OR.
        cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 4'b1010; cmd_b = 4'b1100;
        step();
        cmd_valid = 1'b0;
        chk("or exec alu_A", alu_A, 4'b1010);
        chk("or exec result", alu_Result, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        chk("ar rsp_valid", rsp_valid, 0);
        chk("ar acc", acc, 0);
        chk("ar op_count", op_count, 0);
        chk("ar wrap op_count", w_op_count, 0);
        chk("ar cmd_ready", cmd_ready, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar no rsp", rsp_valid, 0);
            chk("ar acc hold", acc, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
